// File: rtl/alu_regfile.sv
// RV32I integer datapath core: 32x32 register file with write-through bypass,
// plus the independent combinational ALU used in EX.
module alu_regfile #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [4:0]      RNUM1,
  input  logic [4:0]      RNUM2,
  output logic [XLEN-1:0] RDATA1,
  output logic [XLEN-1:0] RDATA2,
  input  logic [4:0]      WNUM,
  input  logic [XLEN-1:0] WDATA,
  input  logic [XLEN-1:0] ALU_A,
  input  logic [XLEN-1:0] ALU_B,
  input  logic [4:0]      ALU_OP,
  output logic [XLEN-1:0] ALU_Y
);

  typedef enum logic [4:0] {
    OP_ADD  = 5'd0,
    OP_SUB  = 5'd1,
    OP_SLL  = 5'd2,
    OP_SLT  = 5'd3,
    OP_SLTU = 5'd4,
    OP_XOR  = 5'd5,
    OP_SRL  = 5'd6,
    OP_SRA  = 5'd7,
    OP_OR   = 5'd8,
    OP_AND  = 5'd9
  } alu_op_e;

  logic [XLEN-1:0] r_regs [NREG];
  logic [XLEN-1:0] w_rd1;
  logic [XLEN-1:0] w_rd2;
  logic [XLEN-1:0] w_y;
  logic [4:0]      w_shamt;

  // Entry 0 is never written, so it holds its reset value of zero.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int unsigned i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else if (WNUM != '0) begin
      r_regs[WNUM] <= WDATA;
    end
  end

  // Same-cycle bypass lets WB and ID overlap; RNUMn != 0 implies WNUM != 0 on a hit.
  always_comb begin
    w_rd1 = '0;
    w_rd2 = '0;
    if (!RST && RNUM1 != '0) w_rd1 = (RNUM1 == WNUM) ? WDATA : r_regs[RNUM1];
    if (!RST && RNUM2 != '0) w_rd2 = (RNUM2 == WNUM) ? WDATA : r_regs[RNUM2];
  end

  assign RDATA1 = w_rd1;
  assign RDATA2 = w_rd2;

  always_comb begin
    w_shamt = ALU_B[4:0];
    w_y     = '0;
    case (ALU_OP)
      OP_ADD:  w_y = ALU_A + ALU_B;
      OP_SUB:  w_y = ALU_A - ALU_B;
      OP_SLL:  w_y = ALU_A << w_shamt;
      OP_SLT:  w_y = {{(XLEN-1){1'b0}}, ($signed(ALU_A) < $signed(ALU_B))};
      OP_SLTU: w_y = {{(XLEN-1){1'b0}}, (ALU_A < ALU_B)};
      OP_XOR:  w_y = ALU_A ^ ALU_B;
      OP_SRL:  w_y = ALU_A >> w_shamt;
      OP_SRA:  w_y = $unsigned($signed(ALU_A) >>> w_shamt);
      OP_OR:   w_y = ALU_A | ALU_B;
      OP_AND:  w_y = ALU_A & ALU_B;
      default: w_y = '0;
    endcase
  end

  assign ALU_Y = w_y;

endmodule

// File: tb/tb_alu_regfile.sv
// Scoreboard bench for alu_regfile: directed vectors plus random traffic checked
// against an arithmetic reference model of the register file and ALU.
module tb_alu_regfile;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [4:0]  RNUM1 = '0, RNUM2 = '0, WNUM = '0, ALU_OP = '0;
  logic [31:0] WDATA = '0, ALU_A = '0, ALU_B = '0;
  logic [31:0] RDATA1, RDATA2, ALU_Y;

  alu_regfile #(.XLEN(32), .NREG(32)) dut (
    .CLK(CLK), .RST(RST),
    .RNUM1(RNUM1), .RNUM2(RNUM2), .RDATA1(RDATA1), .RDATA2(RDATA2),
    .WNUM(WNUM), .WDATA(WDATA),
    .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_OP(ALU_OP), .ALU_Y(ALU_Y)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] y;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] model [32];
  int          n_checks = 0;
  int          n_pass   = 0;

  localparam longint unsigned TWO32 = 64'h1_0000_0000;

  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [4:0] op);
    longint unsigned ua, ub, p, t;
    longint          sa, sb;
    ua = {32'b0, a};
    ub = {32'b0, b};
    p  = 64'd2 ** (ub % 64'd32);
    sa = a[31] ? longint'(ua) - longint'(TWO32) : longint'(ua);
    sb = b[31] ? longint'(ub) - longint'(TWO32) : longint'(ub);
    case (op)
      5'd0: t = (ua + ub) % TWO32;
      5'd1: t = (ua + TWO32 - ub) % TWO32;
      5'd2: t = (ua * p) % TWO32;
      5'd3: t = (sa < sb) ? 64'd1 : 64'd0;
      5'd4: t = (ua < ub) ? 64'd1 : 64'd0;
      5'd5: t = {32'b0, a ^ b};
      5'd6: t = ua / p;
      5'd7: t = a[31] ? {32'b0, ~32'(({32'b0, ~a}) / p)} : ua / p;
      5'd8: t = {32'b0, a | b};
      5'd9: t = {32'b0, a & b};
      default: t = 64'd0;
    endcase
    return t[31:0];
  endfunction

  function automatic logic [31:0] ref_rd(input logic rst, input logic [4:0] rn,
                                         input logic [4:0] wn, input logic [31:0] wd);
    if (rst || rn == 5'd0) return 32'd0;
    if (rn == wn) return wd;
    return model[rn];
  endfunction

  // Drive one cycle of stimulus after a rising edge, queue its expectation,
  // then retire the write into the model at the following edge.
  task automatic cyc(input logic rst, input logic [4:0] r1, input logic [4:0] r2,
                     input logic [4:0] wn, input logic [31:0] wd,
                     input logic [31:0] a, input logic [31:0] b, input logic [4:0] op);
    exp_t e;
    RST = rst; RNUM1 = r1; RNUM2 = r2; WNUM = wn; WDATA = wd;
    ALU_A = a; ALU_B = b; ALU_OP = op;
    if (rst) for (int i = 0; i < 32; i++) model[i] = 32'd0;
    e.rd1 = ref_rd(rst, r1, wn, wd);
    e.rd2 = ref_rd(rst, r2, wn, wd);
    e.y   = ref_alu(a, b, op);
    sb_q.push_back(e);
    @(posedge CLK);
    if (!rst && wn != 5'd0) model[wn] = wd;
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLK);
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("RDATA1", RDATA1, e.rd1);
        chk("RDATA2", RDATA2, e.rd2);
        chk("ALU_Y",  ALU_Y,  e.y);
      end
    end
  end

  initial begin : stim
    logic [4:0]  wn, op;
    logic [31:0] b;
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    @(posedge CLK); #1;
    cyc(1'b1, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 5'd0);
    cyc(1'b0, 5'd5, 5'd5, 5'd5, 32'hDEADBEEF, 32'd0, 32'd0, 5'd0);
    cyc(1'b0, 5'd5, 5'd5, 5'd0, 32'd0, 32'd0, 32'd0, 5'd0);
    cyc(1'b0, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFF, 32'd0, 32'd0, 5'd0);
    cyc(1'b0, 5'd0, 5'd5, 5'd0, 32'd0, 32'd0, 32'd0, 5'd0);
    cyc(1'b0, 5'd7, 5'd0, 5'd7, 32'h12345678, 32'd0, 32'd0, 5'd0);
    cyc(1'b0, 5'd7, 5'd7, 5'd0, 32'd0, 32'd0, 32'd0, 5'd0);
    cyc(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'hFFFFFFFF, 32'd1, 5'd0);
    cyc(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd1, 5'd1);
    cyc(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'hFFFFFFFF, 32'd1, 5'd3);
    cyc(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'hFFFFFFFF, 32'd1, 5'd4);
    cyc(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'h80000000, 32'd4, 5'd6);
    cyc(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'h80000000, 32'd4, 5'd7);
    cyc(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd1, 32'h21, 5'd2);
    cyc(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'hF0F0F0F0, 32'hFF00FF00, 5'd5);
    cyc(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'hF0F0F0F0, 32'hFF00FF00, 5'd8);
    cyc(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'hF0F0F0F0, 32'hFF00FF00, 5'd9);
    cyc(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'hF0F0F0F0, 32'hFF00FF00, 5'd15);
    for (int i = 1; i < 32; i++)
      cyc(1'b0, 5'(i), 5'(i), 5'(i), $urandom, 32'd0, 32'd0, 5'd0);
    // Mid-run reset: contents gone while held and after release.
    for (int i = 0; i < 32; i++)
      cyc(1'b1, 5'(i), 5'(31 - i), 5'(i), $urandom, 32'd0, 32'd0, 5'd0);
    for (int i = 0; i < 32; i++)
      cyc(1'b0, 5'(i), 5'(31 - i), 5'd0, $urandom, 32'd0, 32'd0, 5'd0);
    for (int i = 0; i < 400; i++) begin
      wn = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      op = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(10, 31))
                                       : 5'($urandom_range(0, 9));
      b  = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      cyc(($urandom_range(0, 99) == 0), 5'($urandom_range(0, 31)),
          5'($urandom_range(0, 31)), wn, $urandom, $urandom, b, op);
    end
    cyc(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'h7FFFFFFF, 32'h80000000, 5'd3);
    cyc(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'h7FFFFFFF, 32'h80000000, 5'd4);
    cyc(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'hC0000001, 32'hFFFFFFFF, 5'd7);
    @(negedge CLK);
    @(negedge CLK);
    n_checks++;
    if (sb_q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
